mcpu_bus_arbiter: RTL and testbench

//  N-channel successor to the single-CPU bus bridge: arbitrates N_CPU cores' read_q/write_q

---
 rtl/mcpu_bus_arbiter_pkg.sv | 16 +
 rtl/mcpu_bus_arbiter_if.sv | 43 ++++
 rtl/mcpu_bus_arbiter_rr_pick.sv | 35 +++
 rtl/mcpu_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mcpu_bus_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_bus_arbiter_pkg.sv
// Shared definitions for mcpu bus masters: FSM state codes and transaction opcodes.
package mcpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/mcpu_bus_arbiter_if.sv
// Bundle of CPU-side request/done signals and memory-side bus signals around the arbiter.
interface mcpu_bus_arbiter_if #(
    parameter int N_CPU  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int IDX_W = $clog2(N_CPU);

    logic                     halt_q;
    logic [N_CPU-1:0]         cpu_read_q;
    logic [N_CPU-1:0]         cpu_write_q;
    logic [N_CPU*ADDR_W-1:0]  cpu_addr;
    logic [N_CPU*DATA_W-1:0]  cpu_wdata;
    logic [DATA_W-1:0]        cpu_rdata;
    logic [N_CPU-1:0]         cpu_read_dn;
    logic [N_CPU-1:0]         cpu_write_dn;
    logic                     cpu_err;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_wdata;
    logic                     mem_read_q;
    logic                     mem_write_q;
    logic [DATA_W-1:0]        mem_rdata;
    logic                     mem_read_dn;
    logic                     mem_write_dn;
    logic                     bus_busy;
    logic [IDX_W-1:0]         grant_idx;

    // The arbiter is the master: it serves the cores and drives the memory bus.
    modport master (
        input  halt_q, cpu_read_q, cpu_write_q, cpu_addr, cpu_wdata,
               mem_rdata, mem_read_dn, mem_write_dn,
        output cpu_rdata, cpu_read_dn, cpu_write_dn, cpu_err,
               mem_addr, mem_wdata, mem_read_q, mem_write_q, bus_busy, grant_idx
    );

    modport slave (
        output halt_q, cpu_read_q, cpu_write_q, cpu_addr, cpu_wdata,
               mem_rdata, mem_read_dn, mem_write_dn,
        input  cpu_rdata, cpu_read_dn, cpu_write_dn, cpu_err,
               mem_addr, mem_wdata, mem_read_q, mem_write_q, bus_busy, grant_idx
    );

endinterface

// File: rtl/mcpu_bus_arbiter_rr_pick.sv
// Combinational round-robin select: first requesting index at or after rr_ptr, wrapping mod N.
module mcpu_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_ptr,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);
    localparam int IDX_W = $clog2(N);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] pos_idx;
    logic             found;

    always_comb begin
        valid   = |req;
        idx     = '0;
        found   = 1'b0;
        pos     = '0;
        pos_idx = '0;
        for (int i = 0; i < N; i++) begin
            pos = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N)) begin
                pos = pos - (IDX_W+1)'(N);
            end
            pos_idx = pos[IDX_W-1:0];
            if (!found && req[pos_idx]) begin
                found = 1'b1;
                idx   = pos_idx;
            end
        end
    end

endmodule

// File: rtl/mcpu_bus_arbiter.sv
// Round-robin arbiter putting N_CPU cores onto one memory bus, one transaction at a time.
// Optional WAIT timeout abort is enabled by defining MCPU_ARB_TIMEOUT_EN.
module mcpu_bus_arbiter
    import mcpu_bus_pkg::*;
#(
    parameter int N_CPU   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input logic                clk,
    input logic                rst_n,
    mcpu_bus_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(N_CPU);

    state_t            state;
    state_t            state_next;
    logic              grant;
    logic              complete;
    logic              abort;
    logic              timeout_hit;
    logic              mem_dn;
    logic [N_CPU-1:0]  req;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  rr_next;
    logic [IDX_W-1:0]  grant_idx;
    logic [N_CPU-1:0]  grant_onehot;
    op_t               op;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              cpu_err;
    logic [N_CPU-1:0]  cpu_read_dn;
    logic [N_CPU-1:0]  cpu_write_dn;

    assign req = bus.cpu_read_q | bus.cpu_write_q;

    mcpu_rr_pick #(.N(N_CPU)) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_comb begin
        pick_addr  = '0;
        pick_wdata = '0;
        for (int k = 0; k < N_CPU; k++) begin
            if (pick_idx == IDX_W'(k)) begin
                pick_addr  = bus.cpu_addr[k*ADDR_W +: ADDR_W];
                pick_wdata = bus.cpu_wdata[k*DATA_W +: DATA_W];
            end
        end
    end

    // Only the done strobe matching the latched op completes the transaction.
    assign mem_dn       = (op == OP_WR) ? bus.mem_write_dn : bus.mem_read_dn;
    assign grant_onehot = N_CPU'(1) << grant_idx;
    assign rr_next      = (grant_idx == IDX_W'(N_CPU-1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef MCPU_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT+1);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == ST_REQ) begin
            wait_cnt <= '0;
        end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT-1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!bus.halt_q && pick_valid) begin
                    grant      = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A done arriving together with the timeout still completes normally.
                if (mem_dn) begin
                    complete   = 1'b1;
                    state_next = ST_DONE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            grant_idx    <= '0;
            op           <= OP_RD;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            cpu_rdata    <= '0;
            cpu_read_dn  <= '0;
            cpu_write_dn <= '0;
            cpu_err      <= 1'b0;
        end else begin
            cpu_read_dn  <= '0;
            cpu_write_dn <= '0;
            cpu_err      <= 1'b0;
            // Writes win when a core raises both requests; its read waits for its next turn.
            if (grant) begin
                grant_idx <= pick_idx;
                mem_addr  <= pick_addr;
                mem_wdata <= pick_wdata;
                if (bus.cpu_write_q[pick_idx]) begin
                    op          <= OP_WR;
                    mem_write_q <= 1'b1;
                end else begin
                    op         <= OP_RD;
                    mem_read_q <= 1'b1;
                end
            end
            if (complete || abort) begin
                mem_read_q  <= 1'b0;
                mem_write_q <= 1'b0;
                cpu_err     <= abort;
                if (op == OP_WR) begin
                    cpu_write_dn <= grant_onehot;
                end else begin
                    cpu_read_dn <= grant_onehot;
                end
                if (abort) begin
                    cpu_rdata <= '1;
                end else if (op == OP_RD) begin
                    cpu_rdata <= bus.mem_rdata;
                end
            end
            if (state == ST_DONE) begin
                rr_ptr <= rr_next;
            end
        end
    end

    assign bus.bus_busy     = (state != ST_IDLE);
    assign bus.grant_idx    = grant_idx;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_wdata    = mem_wdata;
    assign bus.mem_read_q   = mem_read_q;
    assign bus.mem_write_q  = mem_write_q;
    assign bus.cpu_rdata    = cpu_rdata;
    assign bus.cpu_read_dn  = cpu_read_dn;
    assign bus.cpu_write_dn = cpu_write_dn;
    assign bus.cpu_err      = cpu_err;

endmodule

// File: tb/tb_mcpu_bus_arbiter.sv
// Directed self-checking bench for mcpu_bus_arbiter (4 cores, TIMEOUT=8).
module tb_mcpu_bus_arbiter;

    localparam int N_CPU   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          compared = 0;
    int          mismatched = 0;
    logic        mem_auto = 1'b0;
    logic        force_rdn = 1'b0;
    logic        force_wdn = 1'b0;
    logic [31:0] mem_data = 32'h0;

    mcpu_bus_arbiter_if #(.N_CPU(N_CPU), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mcpu_bus_arbiter #(
        .N_CPU   (N_CPU),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Memory model: in auto mode it answers a request seen at negedge, landing in the first WAIT cycle.
    always @(negedge clk) begin
        if (mem_auto) begin
            bus.mem_read_dn  = bus.mem_read_q;
            bus.mem_write_dn = bus.mem_write_q;
        end else begin
            bus.mem_read_dn  = force_rdn;
            bus.mem_write_dn = force_wdn;
        end
        bus.mem_rdata = mem_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] rd, input logic [3:0] wr, input logic halt);
        bus.cpu_read_q  = rd;
        bus.cpu_write_q = wr;
        bus.halt_q      = halt;
    endtask

    task automatic setCore(input int k, input logic [31:0] addr, input logic [31:0] wdata);
        bus.cpu_addr[k*ADDR_W +: ADDR_W]  = addr;
        bus.cpu_wdata[k*DATA_W +: DATA_W] = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        tick();
        tick();

        $display("[TB] reset state");
        checkOutput("rst_busy",   bus.bus_busy, 0);
        checkOutput("rst_rdq",    bus.mem_read_q, 0);
        checkOutput("rst_wrq",    bus.mem_write_q, 0);
        checkOutput("rst_rdn",    bus.cpu_read_dn, 0);
        checkOutput("rst_rdata",  bus.cpu_rdata, 0);
        checkOutput("rst_grant",  bus.grant_idx, 0);
        checkOutput("rst_addr",   bus.mem_addr, 0);

        $display("[TB] reset during WAIT");
        rst_n = 1'b1;
        setCore(2, 32'h100, 32'h0);
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        tick();
        checkOutput("t1_req_rdq", bus.mem_read_q, 1);
        tick();
        checkOutput("t1_wait_busy", bus.bus_busy, 1);
        rst_n = 1'b0;
        tick();
        checkOutput("t1_rst_rdq",   bus.mem_read_q, 0);
        checkOutput("t1_rst_busy",  bus.bus_busy, 0);
        checkOutput("t1_rst_rdn",   bus.cpu_read_dn, 0);
        checkOutput("t1_rst_grant", bus.grant_idx, 0);
        tick();
        checkOutput("t1_rst2_rdn",  bus.cpu_read_dn, 0);
        checkOutput("t1_rst2_rdq",  bus.mem_read_q, 0);

        $display("[TB] single read core2");
        rst_n    = 1'b1;
        mem_auto = 1'b1;
        mem_data = 32'hDEADBEEF;
        tick();
        checkOutput("t2_rdq",    bus.mem_read_q, 1);
        checkOutput("t2_addr",   bus.mem_addr, 32'h100);
        checkOutput("t2_grant",  bus.grant_idx, 2);
        checkOutput("t2_rdn_t1", bus.cpu_read_dn, 0);
        tick();
        checkOutput("t2_rdn_t2", bus.cpu_read_dn, 0);
        tick();
        checkOutput("t2_rdn_t3", bus.cpu_read_dn, 4'b0100);
        checkOutput("t2_rdata",  bus.cpu_rdata, 32'hDEADBEEF);
        checkOutput("t2_err",    bus.cpu_err, 0);
        checkOutput("t2_rdq_off", bus.mem_read_q, 0);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("t2_idle_rdn",   bus.cpu_read_dn, 0);
        checkOutput("t2_idle_busy",  bus.bus_busy, 0);
        checkOutput("t2_hold_rdata", bus.cpu_rdata, 32'hDEADBEEF);
        checkOutput("t2_hold_grant", bus.grant_idx, 2);

        $display("[TB] round robin writes");
        rst_n = 1'b0;
        tick();
        for (int k = 0; k < N_CPU; k++) begin
            setCore(k, 32'h1000 + 32'(k) * 32'h10, 32'hA0 + 32'(k));
        end
        applyStimulus(4'b0000, 4'b1111, 1'b0);
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            int exp_core;
            exp_core = n % N_CPU;
            tick();
            checkOutput($sformatf("t3_grant%0d", n), bus.grant_idx, exp_core);
            checkOutput($sformatf("t3_wrq%0d", n), bus.mem_write_q, 1);
            checkOutput($sformatf("t3_addr%0d", n), bus.mem_addr, 32'h1000 + 32'(exp_core) * 32'h10);
            checkOutput($sformatf("t3_wdata%0d", n), bus.mem_wdata, 32'hA0 + 32'(exp_core));
            tick();
            tick();
            checkOutput($sformatf("t3_wdn%0d", n), bus.cpu_write_dn, 4'b0001 << exp_core);
            tick();
            checkOutput($sformatf("t3_idle_wdn%0d", n), bus.cpu_write_dn, 0);
            checkOutput($sformatf("t3_idle_busy%0d", n), bus.bus_busy, 0);
        end
        applyStimulus(4'b0000, 4'b0000, 1'b0);

        $display("[TB] read+write on core1");
        setCore(1, 32'h200, 32'h55);
        mem_data = 32'h12345678;
        applyStimulus(4'b0010, 4'b0010, 1'b0);
        tick();
        checkOutput("t4_wrq",   bus.mem_write_q, 1);
        checkOutput("t4_rdq",   bus.mem_read_q, 0);
        checkOutput("t4_grant", bus.grant_idx, 1);
        checkOutput("t4_wdata", bus.mem_wdata, 32'h55);
        tick();
        tick();
        checkOutput("t4_wdn",     bus.cpu_write_dn, 4'b0010);
        checkOutput("t4_rdn_no",  bus.cpu_read_dn, 0);
        applyStimulus(4'b0010, 4'b0000, 1'b0);
        tick();
        tick();
        checkOutput("t4_rdq2",   bus.mem_read_q, 1);
        checkOutput("t4_grant2", bus.grant_idx, 1);
        tick();
        tick();
        checkOutput("t4_rdn",   bus.cpu_read_dn, 4'b0010);
        checkOutput("t4_rdata", bus.cpu_rdata, 32'h12345678);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();

        $display("[TB] halt during WAIT");
        mem_auto = 1'b0;
        setCore(3, 32'h300, 32'h77);
        applyStimulus(4'b0000, 4'b1000, 1'b0);
        tick();
        checkOutput("t5_grant", bus.grant_idx, 3);
        applyStimulus(4'b0000, 4'b1000, 1'b1);
        tick();
        tick();
        checkOutput("t5_wrq_held", bus.mem_write_q, 1);
        force_wdn = 1'b1;
        tick();
        checkOutput("t5_wdn", bus.cpu_write_dn, 4'b1000);
        force_wdn = 1'b0;
        setCore(0, 32'h400, 32'h0);
        applyStimulus(4'b0001, 4'b1000, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("t5_halt_busy", bus.bus_busy, 0);
        checkOutput("t5_halt_wrq",  bus.mem_write_q, 0);
        checkOutput("t5_halt_rdq",  bus.mem_read_q, 0);
        applyStimulus(4'b0001, 4'b1000, 1'b0);
        mem_auto = 1'b1;
        mem_data = 32'hCAFEF00D;
        tick();
        checkOutput("t5_wrap_grant", bus.grant_idx, 0);
        checkOutput("t5_wrap_rdq",   bus.mem_read_q, 1);
        checkOutput("t5_wrap_wrq",   bus.mem_write_q, 0);
        tick();
        tick();
        checkOutput("t5_rdn",   bus.cpu_read_dn, 4'b0001);
        checkOutput("t5_rdata", bus.cpu_rdata, 32'hCAFEF00D);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();

        $display("[TB] stalled memory");
        mem_auto = 1'b0;
        setCore(2, 32'h500, 32'h0);
        applyStimulus(4'b0100, 4'b0000, 1'b0);
        tick();
        checkOutput("t6_grant", bus.grant_idx, 2);
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            checkOutput($sformatf("t6_wait_rdq%0d", i), bus.mem_read_q, 1);
        end
`ifdef MCPU_ARB_TIMEOUT_EN
        tick();
        checkOutput("t6_to_rdq",   bus.mem_read_q, 0);
        checkOutput("t6_to_rdn",   bus.cpu_read_dn, 4'b0100);
        checkOutput("t6_to_err",   bus.cpu_err, 1);
        checkOutput("t6_to_rdata", bus.cpu_rdata, 32'hFFFFFFFF);
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("t6_err_clr",  bus.cpu_err, 0);
        checkOutput("t6_idle",     bus.bus_busy, 0);
`else
        tick();
        checkOutput("t6_still_rdq",  bus.mem_read_q, 1);
        checkOutput("t6_still_rdn",  bus.cpu_read_dn, 0);
        checkOutput("t6_still_err",  bus.cpu_err, 0);
        mem_data  = 32'h0BADF00D;
        force_rdn = 1'b1;
        tick();
        checkOutput("t6_rdn",   bus.cpu_read_dn, 4'b0100);
        checkOutput("t6_err",   bus.cpu_err, 0);
        checkOutput("t6_rdata", bus.cpu_rdata, 32'h0BADF00D);
        force_rdn = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 1'b0);
        tick();
        checkOutput("t6_idle", bus.bus_busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
